// File: rtl/alu_exec_unit_if.sv
// Valid/ready bundle between the operand side and the EX/MEM side.
// slave is the ALU end; master is the producer/consumer end.
interface alu_exec_unit_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        Operation;
    logic [DATA_W-1:0] SrcA;
    logic [DATA_W-1:0] SrcB;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ALUResult;
    logic              Zero;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result/Zero and valid/ready handshakes.
// Define BARREL_SHIFT_EN for single-cycle shifts; default is 1 bit/cycle.
module alu_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    output logic           busy,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1010;

    logic [3:0]         op;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  alu_res;
    logic [DATA_W-1:0]  res_q;
    logic               zero_q;
    logic               valid_q;
    logic               in_ready;
    logic               accept;
    logic               xfer;

    assign op    = bus.Operation;
    assign a     = bus.SrcA;
    assign b     = bus.SrcB;
    assign shamt = bus.SrcB[SHAMT_W-1:0];

    assign accept = bus.in_valid && in_ready;
    assign xfer   = valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.ALUResult = res_q;
    assign bus.Zero      = zero_q;

    // Single-cycle result; iterative shifts only use the shamt=0 pass-through
    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_AND:         alu_res = a & b;
            OP_XOR:         alu_res = a ^ b;
            OP_OR:          alu_res = a | b;
            OP_ADD:         alu_res = a + b;
            OP_SUB, OP_BEQ: alu_res = a - b;
            OP_SLT:         alu_res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_PASS:        alu_res = b;
`ifdef BARREL_SHIFT_EN
            OP_SLL:         alu_res = a << shamt;
            OP_SRL:         alu_res = a >> shamt;
            OP_SRA:         alu_res = DATA_W'($signed(a) >>> shamt);
`else
            OP_SLL, OP_SRL, OP_SRA: alu_res = a;
`endif
            default:        alu_res = '0;
        endcase
    end

`ifdef BARREL_SHIFT_EN
    assign busy     = 1'b0;
    assign in_ready = !flush && (!valid_q || bus.out_ready);

    // Output register: flush drops the pending result, accept loads a new one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else begin
            if (xfer) valid_q <= 1'b0;
            if (accept) begin
                res_q   <= alu_res;
                zero_q  <= (alu_res == '0);
                valid_q <= 1'b1;
            end
        end
    end
`else
    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shty_t;

    state_t             state;
    shty_t              shty;
    shty_t              sh_sel;
    logic [SHAMT_W-1:0] cnt;
    logic [DATA_W-1:0]  work;
    logic [DATA_W-1:0]  step;
    logic               is_shift;

    assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    assign busy     = (state == SHIFT);
    assign in_ready = (state == IDLE) && !flush && (!valid_q || bus.out_ready);

    // Shift kind latched at accept
    always_comb begin
        sh_sel = SH_LL;
        if (op == OP_SRL) sh_sel = SH_RL;
        if (op == OP_SRA) sh_sel = SH_RA;
    end

    // One-bit shift of the work register
    always_comb begin
        step = {work[DATA_W-2:0], 1'b0};
        if (shty == SH_RL) step = {1'b0, work[DATA_W-1:1]};
        if (shty == SH_RA) step = {work[DATA_W-1], work[DATA_W-1:1]};
    end

    // Control FSM and result register; flush wins over everything but reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shty    <= SH_LL;
            cnt     <= '0;
            work    <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) valid_q <= 1'b0;
                    if (accept) begin
                        if (is_shift && shamt != '0) begin
                            state <= SHIFT;
                            work  <= a;
                            cnt   <= shamt;
                            shty  <= sh_sel;
                        end else begin
                            res_q   <= alu_res;
                            zero_q  <= (alu_res == '0);
                            valid_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work <= step;
                    cnt  <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        res_q   <= step;
                        zero_q  <= (step == '0);
                        valid_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end
`endif
endmodule
